// File: rtl/fetch_pkg.sv
// Shared defaults, queue entry layout and sizing helper for the instruction fetch front end.
package fetch_pkg;

  localparam int FETCH_ADDR_WIDTH = 16;
  localparam int FETCH_DATA_WIDTH = 16;
  localparam logic [FETCH_ADDR_WIDTH-1:0] FETCH_RESET_VECTOR = 16'h0000;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] pc;
    logic [FETCH_DATA_WIDTH-1:0] word;
  } fetch_entry_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int fetch_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO with a synchronous flush; DEPTH must be a power of two.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = fetch_count_width(DEPTH),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  // Qualify push/pop: flush wins, pushes never overrun and pops never underrun.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (flush) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = push && (count_r != CW'(DEPTH));
      pop_s  = pop && (count_r != {CW{1'b0}});
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are meaningless until written so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: fetch PC, single outstanding read tracking and a prefetch queue.
// Optional macro FETCH_BYPASS_EN lets an arriving word reach the consumer in its arrival cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(FETCH_RESET_VECTOR),
  localparam int CW = fetch_count_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_in_n,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_grant,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  output logic [CW-1:0]         queue_count
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] word;
  } entry_t;

  localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] inflight_pc_r;
  logic                  inflight_r;
  logic                  inflight_epoch_r;
  logic                  epoch_r;

  logic [CW:0]           occupancy_s;
  logic                  take_s;
  logic                  rsp_live_s;
  logic                  bypass_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_valid_s;
  logic [CW-1:0]         count_s;
  entry_t                push_entry_s;
  entry_t                head_entry_s;

  // Request rule, response qualification and head/bypass output selection.
  always_comb begin
    occupancy_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
    if (reset_in_n && !redirect && (occupancy_s < DEPTH_OCC)) begin
      mem_req = 1'b1;
    end else begin
      mem_req = 1'b0;
    end
    take_s       = mem_req && mem_grant;
    // A stale epoch or a redirect this cycle kills the returning word.
    rsp_live_s   = inflight_r && (inflight_epoch_r == epoch_r) && !redirect;
    push_entry_s = '{pc: inflight_pc_r, word: mem_data};
    fifo_valid_s = (count_s != {CW{1'b0}});
`ifdef FETCH_BYPASS_EN
    bypass_s     = rsp_live_s && !fifo_valid_s;
`else
    bypass_s     = 1'b0;
`endif
    if (bypass_s) begin
      instr_valid = 1'b1;
      instr       = mem_data;
      instr_pc    = inflight_pc_r;
    end else begin
      instr_valid = fifo_valid_s;
      instr       = head_entry_s.word;
      instr_pc    = head_entry_s.pc;
    end
    push_s = rsp_live_s && !(bypass_s && instr_ready);
    pop_s  = fifo_valid_s && instr_ready;
  end

  // Fetch PC, outstanding-read tag and flush epoch.
  always_ff @(posedge clk) begin
    if (!reset_in_n) begin
      pc_r             <= RESET_VECTOR;
      inflight_pc_r    <= RESET_VECTOR;
      inflight_r       <= 1'b0;
      inflight_epoch_r <= 1'b0;
      epoch_r          <= 1'b0;
    end else begin
      inflight_r <= take_s;
      if (take_s) begin
        inflight_pc_r    <= pc_r;
        inflight_epoch_r <= epoch_r;
      end
      if (redirect) begin
        pc_r    <= redirect_addr;
        epoch_r <= ~epoch_r;
      end else if (take_s) begin
        pc_r <= pc_r + ADDR_WIDTH'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH($bits(entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_in_n),
    .flush    (redirect),
    .push     (push_s),
    .push_data(push_entry_s),
    .pop      (pop_s),
    .head_data(head_entry_s),
    .count    (count_s)
  );

  assign mem_addr    = pc_r;
  assign queue_count = count_s;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: per-cycle vector table plus directed multi-cycle sequences.
module tb_fetch_queue;

  logic        clk;
  logic        reset_in_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_grant;
  logic [15:0] mem_data;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  queue_count;

  int n_checks = 0;
  int n_errors = 0;
  int taken_cnt = 0;
  logic        pend_v = 1'b0;
  logic [15:0] pend_a = 16'h0000;
  logic [15:0] got_pc[$];
  logic [15:0] got_data[$];

  fetch_queue #(
    .ADDR_WIDTH  (16),
    .DATA_WIDTH  (16),
    .DEPTH       (4),
    .RESET_VECTOR(16'h0010)
  ) dut (
    .clk          (clk),
    .reset_in_n   (reset_in_n),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_grant    (mem_grant),
    .mem_data     (mem_data),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .queue_count  (queue_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model and transfer monitor, sampled away from the active edge.
  always @(negedge clk) begin
    pend_v = mem_req && mem_grant;
    pend_a = mem_addr;
    if (pend_v) taken_cnt++;
    if (instr_valid && instr_ready) begin
      got_pc.push_back(instr_pc);
      got_data.push_back(instr);
    end
  end

  always @(posedge clk) begin
    mem_data <= pend_v ? (pend_a ^ 16'hA5A5) : 16'h0BAD;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        grant;
    logic        ready;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic g, input logic r, input logic req, input logic [15:0] a,
                              input logic v, input logic [15:0] pc, input logic [2:0] c);
    vec_t t;
    t.grant = g; t.ready = r; t.exp_req = req; t.exp_addr = a;
    t.exp_valid = v; t.exp_pc = pc; t.exp_count = c;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic rdy);
    reset_in_n = 1'b0;
    mem_grant = 1'b1;
    instr_ready = rdy;
    redirect = 1'b0;
    tick();
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_queue_count", {29'd0, queue_count}, 32'd0);
    tick();
    reset_in_n = 1'b1;
  endtask

  task automatic wait_pops(input int base, input int n, input string name);
    int budget;
    budget = 200;
    while ((got_pc.size() < base + n) && (budget > 0)) begin
      tick();
      budget--;
    end
    check(name, {31'd0, (got_pc.size() >= base + n)}, 32'd1);
  endtask

  task automatic check_pop(input int base, input int idx, input logic [15:0] exp_pc, input string name);
    if (base + idx < got_pc.size()) begin
      check({name, "_pc"}, {16'd0, got_pc[base + idx]}, {16'd0, exp_pc});
      check({name, "_data"}, {16'd0, got_data[base + idx]}, {16'd0, exp_pc ^ 16'hA5A5});
    end else begin
      check({name, "_missing"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    int base;
    int base_take;
    logic [15:0] frozen;
    bit found;

    reset_in_n = 1'b0;
    mem_grant = 1'b0;
    redirect = 1'b0;
    redirect_addr = 16'h0000;
    instr_ready = 1'b0;

`ifdef FETCH_BYPASS_EN
    vecs[0] = mk(1'b1, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 3'd0);
    vecs[1] = mk(1'b1, 1'b1, 1'b1, 16'h0011, 1'b1, 16'h0010, 3'd0);
    vecs[2] = mk(1'b1, 1'b1, 1'b1, 16'h0012, 1'b1, 16'h0011, 3'd0);
    vecs[3] = mk(1'b1, 1'b1, 1'b1, 16'h0013, 1'b1, 16'h0012, 3'd0);
    vecs[4] = mk(1'b1, 1'b1, 1'b1, 16'h0014, 1'b1, 16'h0013, 3'd0);
    vecs[5] = mk(1'b1, 1'b0, 1'b1, 16'h0015, 1'b1, 16'h0014, 3'd0);
    vecs[6] = mk(1'b1, 1'b0, 1'b1, 16'h0016, 1'b1, 16'h0014, 3'd1);
`else
    vecs[0] = mk(1'b1, 1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 3'd0);
    vecs[1] = mk(1'b1, 1'b1, 1'b1, 16'h0011, 1'b0, 16'h0000, 3'd0);
    vecs[2] = mk(1'b1, 1'b1, 1'b1, 16'h0012, 1'b1, 16'h0010, 3'd1);
    vecs[3] = mk(1'b1, 1'b1, 1'b1, 16'h0013, 1'b1, 16'h0011, 3'd1);
    vecs[4] = mk(1'b1, 1'b1, 1'b1, 16'h0014, 1'b1, 16'h0012, 3'd1);
    vecs[5] = mk(1'b1, 1'b0, 1'b1, 16'h0015, 1'b1, 16'h0013, 3'd1);
    vecs[6] = mk(1'b1, 1'b0, 1'b1, 16'h0016, 1'b1, 16'h0013, 3'd2);
`endif

    // Streaming from reset: latency, PC sequence and data.
    apply_reset(1'b1);
    for (int i = 0; i < 7; i++) begin
      mem_grant = vecs[i].grant;
      instr_ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("vec%0d_mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].exp_req});
      check($sformatf("vec%0d_mem_addr", i), {16'd0, mem_addr}, {16'd0, vecs[i].exp_addr});
      check($sformatf("vec%0d_instr_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_queue_count", i), {29'd0, queue_count}, {29'd0, vecs[i].exp_count});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_instr_pc", i), {16'd0, instr_pc}, {16'd0, vecs[i].exp_pc});
        check($sformatf("vec%0d_instr", i), {16'd0, instr}, {16'd0, vecs[i].exp_pc ^ 16'hA5A5});
      end
      tick();
    end

    // Consumer stalled: queue fills to DEPTH, requests stop, outputs hold.
    apply_reset(1'b0);
    base_take = taken_cnt;
    repeat (8) tick();
    @(negedge clk);
    check("full_takes", taken_cnt - base_take, 32'd4);
    check("full_count", {29'd0, queue_count}, 32'd4);
    check("full_mem_req", {31'd0, mem_req}, 32'd0);
    check("full_valid", {31'd0, instr_valid}, 32'd1);
    check("full_head_pc", {16'd0, instr_pc}, 32'h0010);
    repeat (2) tick();
    @(negedge clk);
    check("full_hold_pc", {16'd0, instr_pc}, 32'h0010);
    check("full_hold_count", {29'd0, queue_count}, 32'd4);
    check("full_hold_takes", taken_cnt - base_take, 32'd4);
    tick();
    instr_ready = 1'b1;
    base = got_pc.size();
    wait_pops(base, 8, "drain_timeout");
    for (int i = 0; i < 8; i++) check_pop(base, i, 16'h0010 + 16'(i), $sformatf("drain%0d", i));
    check("drain_resumed", {31'd0, ((taken_cnt - base_take) >= 8)}, 32'd1);

    // Redirect the cycle after the request to 0x0013 is taken.
    apply_reset(1'b1);
    base = got_pc.size();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_grant && mem_addr == 16'h0013) found = 1'b1;
      tick();
    end
    check("redir_found_0013", {31'd0, found}, 32'd1);
    redirect = 1'b1;
    redirect_addr = 16'h0200;
    @(negedge clk);
    check("redir_no_req", {31'd0, mem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check("redir_count", {29'd0, queue_count}, 32'd0);
    check("redir_valid", {31'd0, instr_valid}, 32'd0);
    check("redir_addr", {16'd0, mem_addr}, 32'h0200);
    check("redir_req", {31'd0, mem_req}, 32'd1);
    wait_pops(base, 6, "redir_timeout");
    check_pop(base, 0, 16'h0010, "redir0");
    check_pop(base, 1, 16'h0011, "redir1");
    check_pop(base, 2, 16'h0012, "redir2");
    check_pop(base, 3, 16'h0200, "redir3");
    check_pop(base, 4, 16'h0201, "redir4");
    check_pop(base, 5, 16'h0202, "redir5");

    // Grant withheld for 5 cycles mid-stream.
    apply_reset(1'b1);
    base = got_pc.size();
    repeat (4) tick();
    mem_grant = 1'b0;
    @(negedge clk);
    frozen = mem_addr;
    repeat (4) tick();
    @(negedge clk);
    check("grant_pc_frozen", {16'd0, mem_addr}, {16'd0, frozen});
    check("grant_pc_value", {16'd0, mem_addr}, 32'h0014);
    tick();
    mem_grant = 1'b1;
    wait_pops(base, 12, "grant_timeout");
    for (int i = 0; i < 12; i++) check_pop(base, i, 16'h0010 + 16'(i), $sformatf("grant%0d", i));

    // PC wrap from 0xFFFE.
    apply_reset(1'b1);
    base = got_pc.size();
    redirect = 1'b1;
    redirect_addr = 16'hFFFE;
    tick();
    redirect = 1'b0;
    wait_pops(base, 4, "wrap_timeout");
    check_pop(base, 0, 16'hFFFE, "wrap0");
    check_pop(base, 1, 16'hFFFF, "wrap1");
    check_pop(base, 2, 16'h0000, "wrap2");
    check_pop(base, 3, 16'h0001, "wrap3");

    // One-cycle reset with a loaded queue and a read in flight.
    apply_reset(1'b0);
    repeat (4) tick();
    reset_in_n = 1'b0;
    @(negedge clk);
    check("midrst_count_before", {29'd0, queue_count}, 32'd3);
    check("midrst_req_low", {31'd0, mem_req}, 32'd0);
    tick();
    reset_in_n = 1'b1;
    instr_ready = 1'b1;
    base = got_pc.size();
    @(negedge clk);
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_count", {29'd0, queue_count}, 32'd0);
    check("midrst_addr", {16'd0, mem_addr}, 32'h0010);
    check("midrst_req", {31'd0, mem_req}, 32'd1);
    wait_pops(base, 3, "midrst_timeout");
    check_pop(base, 0, 16'h0010, "midrst0");
    check_pop(base, 1, 16'h0011, "midrst1");
    check_pop(base, 2, 16'h0012, "midrst2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
